// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction-fetch stage: program counter, single-outstanding ibus requests, skid buffer
// Feeds the IF/ID register and reports hold_flag_if_o while a fetch is still pending.
module if_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [63:0] jump_addr_i,
  input  logic [1:0]  hold_flag_i,
  output logic        ibus_req_o,
  output logic [63:0] ibus_addr_o,
  input  logic        ibus_ack_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] inst_o,
  output logic [63:0] inst_addr_o,
  output logic        hold_flag_if_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_REQ     = 2'b01,
    S_DISCARD = 2'b10,
    S_BUF     = 2'b11
  } state_t;

  state_t      state, state_next;
  logic [63:0] pc, pc_next;
  logic [63:0] redirect_pc, redirect_next;
  logic [63:0] buf_addr, buf_addr_next;
  logic [31:0] buf_inst, buf_inst_next;
  logic [31:0] inst_next;
  logic [63:0] inst_addr_next;
  logic        flush;
  logic        stall;
  logic [63:0] target;

  // Reserved hold encoding 00 behaves like a stall; only 11 lets the stage advance.
  assign flush  = jump_en_i | (hold_flag_i == 2'b01);
  assign stall  = !flush && (hold_flag_i != 2'b11);
  assign target = jump_addr_i & ~64'h3;

  // The bus address is always pc: during S_DISCARD the new target waits in redirect_pc.
  assign ibus_addr_o = pc;

  always_comb begin
    state_next     = state;
    pc_next        = pc;
    redirect_next  = redirect_pc;
    buf_inst_next  = buf_inst;
    buf_addr_next  = buf_addr;
    inst_next      = inst_o;
    inst_addr_next = inst_addr_o;
    ibus_req_o     = 1'b0;
    hold_flag_if_o = 1'b1;

    case (state)
      S_IDLE: begin
        if (flush) pc_next = target;
        state_next = S_REQ;
      end

      S_REQ: begin
        ibus_req_o     = 1'b1;
        hold_flag_if_o = !ibus_ack_i;
        if (flush) begin
          inst_next      = NOP_INST;
          inst_addr_next = 64'h0;
          if (ibus_ack_i) begin
            pc_next = target;
          end else begin
            redirect_next = target;
            state_next    = S_DISCARD;
          end
        end else if (stall) begin
          if (ibus_ack_i) begin
            buf_inst_next = ibus_rdata_i;
            buf_addr_next = pc;
            pc_next       = pc + 64'd4;
            state_next    = S_BUF;
          end
        end else if (ibus_ack_i) begin
          inst_next      = ibus_rdata_i;
          inst_addr_next = pc;
          pc_next        = pc + 64'd4;
        end else begin
          inst_next      = NOP_INST;
          inst_addr_next = 64'h0;
        end
      end

      S_DISCARD: begin
        ibus_req_o = 1'b1;
        if (flush) redirect_next = target;
        if (ibus_ack_i) begin
          pc_next    = flush ? target : redirect_pc;
          state_next = S_REQ;
        end
      end

      S_BUF: begin
        hold_flag_if_o = 1'b0;
        if (flush) begin
          pc_next        = target;
          inst_next      = NOP_INST;
          inst_addr_next = 64'h0;
          buf_inst_next  = NOP_INST;
          buf_addr_next  = 64'h0;
          state_next     = S_REQ;
        end else if (!stall) begin
          inst_next      = buf_inst;
          inst_addr_next = buf_addr;
          buf_inst_next  = NOP_INST;
          buf_addr_next  = 64'h0;
          state_next     = S_REQ;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      redirect_pc <= RESET_PC;
      buf_inst    <= NOP_INST;
      buf_addr    <= 64'h0;
      inst_o      <= NOP_INST;
      inst_addr_o <= 64'h0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      redirect_pc <= redirect_next;
      buf_inst    <= buf_inst_next;
      buf_addr    <= buf_addr_next;
      inst_o      <= inst_next;
      inst_addr_o <= inst_addr_next;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - self-checking bench for if_fetch
// Reference model tracks fetch phase, pc and output words; compared every cycle plus literal checkpoints.
module tb_if_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_en_i;
  logic [63:0] jump_addr_i;
  logic [1:0]  hold_flag_i;
  logic        ibus_req_o;
  logic [63:0] ibus_addr_o;
  logic        ibus_ack_i;
  logic [31:0] ibus_rdata_i;
  logic [31:0] inst_o;
  logic [63:0] inst_addr_o;
  logic        hold_flag_if_o;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0000;
  endfunction

  assign ibus_rdata_i = mem_word(ibus_addr_o);

  if_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .jump_en_i     (jump_en_i),
    .jump_addr_i   (jump_addr_i),
    .hold_flag_i   (hold_flag_i),
    .ibus_req_o    (ibus_req_o),
    .ibus_addr_o   (ibus_addr_o),
    .ibus_ack_i    (ibus_ack_i),
    .ibus_rdata_i  (ibus_rdata_i),
    .inst_o        (inst_o),
    .inst_addr_o   (inst_addr_o),
    .hold_flag_if_o(hold_flag_if_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 waiting to start, 1 fetching, 2 draining a cancelled fetch, 3 holding a buffered word.
  int          m_phase;
  logic [63:0] m_pc, m_target, m_buf_addr, m_addr;
  logic [31:0] m_buf_inst, m_inst;
  bit          m_ready = 0;

  always @(posedge clk) begin
    logic        fl, st;
    logic [63:0] tg;
    fl = jump_en_i || (hold_flag_i == 2'b01);
    st = !fl && (hold_flag_i != 2'b11);
    tg = {jump_addr_i[63:2], 2'b00};
    if (rst) begin
      m_phase = 0; m_pc = 64'h0; m_inst = NOP; m_addr = 64'h0; m_ready = 1;
    end else if (m_ready) begin
      case (m_phase)
        0: begin
          if (fl) m_pc = tg;
          m_phase = 1;
        end
        1: begin
          if (fl) begin
            m_inst = NOP; m_addr = 64'h0;
            if (ibus_ack_i) m_pc = tg;
            else begin m_target = tg; m_phase = 2; end
          end else if (st) begin
            if (ibus_ack_i) begin
              m_buf_inst = mem_word(m_pc); m_buf_addr = m_pc;
              m_pc = m_pc + 4; m_phase = 3;
            end
          end else if (ibus_ack_i) begin
            m_inst = mem_word(m_pc); m_addr = m_pc; m_pc = m_pc + 4;
          end else begin
            m_inst = NOP; m_addr = 64'h0;
          end
        end
        2: begin
          if (fl) m_target = tg;
          if (ibus_ack_i) begin m_pc = m_target; m_phase = 1; end
        end
        default: begin
          if (fl) begin
            m_pc = tg; m_inst = NOP; m_addr = 64'h0; m_phase = 1;
          end else if (!st) begin
            m_inst = m_buf_inst; m_addr = m_buf_addr; m_phase = 1;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      logic exp_req, exp_hold;
      exp_req  = (m_phase == 1) || (m_phase == 2);
      exp_hold = (m_phase == 0) || (m_phase == 2) || (m_phase == 1 && !ibus_ack_i);
      chk("model_req", 64'(ibus_req_o), 64'(exp_req));
      if (exp_req) chk("model_addr", ibus_addr_o, m_pc);
      chk("model_hold_if", 64'(hold_flag_if_o), 64'(exp_hold));
      chk("model_inst", 64'(inst_o), 64'(m_inst));
      chk("model_inst_addr", inst_addr_o, m_addr);
    end
  end

  task automatic cyc(input logic j, input logic [63:0] ja, input logic [1:0] h, input logic a);
    jump_en_i = j; jump_addr_i = ja; hold_flag_i = h; ibus_ack_i = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; jump_en_i = 1'b0; jump_addr_i = 64'h0; hold_flag_i = 2'b11; ibus_ack_i = 1'b1;
    cyc(0, 0, 2'b11, 1);
    cyc(0, 0, 2'b11, 1);
    chk("rst_req", 64'(ibus_req_o), 64'd0);
    chk("rst_inst", 64'(inst_o), 64'(NOP));
    chk("rst_inst_addr", inst_addr_o, 64'h0);
    chk("rst_hold_if", 64'(hold_flag_if_o), 64'd1);
    rst = 1'b0;

    // Zero-wait streaming from reset
    cyc(0, 0, 2'b11, 1);
    chk("first_req", 64'(ibus_req_o), 64'd1);
    chk("first_addr", ibus_addr_o, 64'h0);
    cyc(0, 0, 2'b11, 1);
    chk("stream_addr4", ibus_addr_o, 64'h4);
    chk("stream_inst0", 64'(inst_o), 64'h5A5A_0000);
    cyc(0, 0, 2'b11, 1);
    chk("stream_addr8", ibus_addr_o, 64'h8);
    chk("stream_iaddr4", inst_addr_o, 64'h4);

    // Ack delayed three cycles at 0x10
    cyc(1, 64'h10, 2'b11, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 2'b11, 0);
      chk("wait_addr", ibus_addr_o, 64'h10);
      chk("wait_inst_nop", 64'(inst_o), 64'(NOP));
    end
    cyc(0, 0, 2'b11, 1);
    chk("wait_iaddr", inst_addr_o, 64'h10);
    chk("wait_inst", 64'(inst_o), 64'h5A5A_0010);

    // Flush to 0x203 while the fetch at 0x20 is pending
    cyc(1, 64'h20, 2'b11, 1);
    cyc(1, 64'h203, 2'b11, 0);
    chk("disc_addr_a", ibus_addr_o, 64'h20);
    cyc(0, 0, 2'b11, 0);
    chk("disc_addr_b", ibus_addr_o, 64'h20);
    chk("disc_inst", 64'(inst_o), 64'(NOP));
    cyc(0, 0, 2'b11, 1);
    chk("disc_redirect", ibus_addr_o, 64'h200);
    chk("disc_dropped", 64'(inst_o), 64'(NOP));

    // Stall with ack at 0x40, released two cycles later
    cyc(1, 64'h40, 2'b11, 1);
    cyc(0, 0, 2'b10, 1);
    chk("buf_req", 64'(ibus_req_o), 64'd0);
    chk("buf_inst_hold", 64'(inst_o), 64'(NOP));
    cyc(0, 0, 2'b10, 0);
    cyc(0, 0, 2'b11, 0);
    chk("buf_iaddr", inst_addr_o, 64'h40);
    chk("buf_inst", 64'(inst_o), 64'h5A5A_0040);
    chk("buf_next_addr", ibus_addr_o, 64'h44);

    // Flush out of the skid buffer
    cyc(0, 0, 2'b10, 1);
    cyc(1, 64'h80, 2'b11, 0);
    chk("bufflush_addr", ibus_addr_o, 64'h80);
    chk("bufflush_inst", 64'(inst_o), 64'(NOP));

    // pc wrap, reserved hold code, bubble
    cyc(1, 64'hFFFF_FFFF_FFFF_FFFC, 2'b11, 1);
    cyc(0, 0, 2'b11, 1);
    chk("wrap_iaddr", inst_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_addr", ibus_addr_o, 64'h0);
    cyc(0, 0, 2'b00, 0);
    chk("hold00_inst", 64'(inst_o), 64'hA5A5_FFFC);
    cyc(0, 0, 2'b11, 0);
    chk("bubble_inst", 64'(inst_o), 64'(NOP));

    // Second flush during discard wins
    cyc(1, 64'h100, 2'b11, 0);
    cyc(0, 0, 2'b01, 0);
    cyc(1, 64'h300, 2'b11, 1);
    chk("lastwins_addr", ibus_addr_o, 64'h300);

    // Reset while discarding
    cyc(1, 64'h500, 2'b11, 0);
    rst = 1'b1;
    cyc(0, 0, 2'b11, 1);
    chk("rstdisc_req", 64'(ibus_req_o), 64'd0);
    chk("rstdisc_inst", 64'(inst_o), 64'(NOP));
    rst = 1'b0;
    cyc(0, 0, 2'b11, 1);
    chk("rstdisc_addr", ibus_addr_o, 64'h0);
    cyc(0, 0, 2'b11, 1);
    cyc(0, 0, 2'b11, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
